// File: rtl/au_pkg.sv
// Shared constants and helpers for the arithmetic-unit adder family.
// The ARCH encodings select the carry network used by au_carry_net.
package au_pkg;

  localparam int AU_ARCH_RCA         = 0;
  localparam int AU_ARCH_SKLANSKY    = 1;
  localparam int AU_ARCH_KOGGE_STONE = 2;

  // Number of prefix levels needed to span n positions: clog2(n), at least 1.
  function automatic int au_prefix_levels(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/au_carry_net.sv
// Carry network: turns per-bit generate/propagate plus carry-in into the
// carry vector c[WIDTH:0], where c[i] is the carry into bit i.
module au_carry_net
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = AU_ARCH_RCA
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             ci,
  output logic [WIDTH:0]   c
);

  // The carry-in sits at prefix position 0 as a pure generate, so the
  // network spans WIDTH+1 positions and the group generate at position i
  // is exactly the carry into bit i.
  localparam int N      = WIDTH + 1;
  localparam int LEVELS = au_prefix_levels(N);

  if (ARCH == AU_ARCH_RCA) begin : g_rca

    always_comb begin
      c[0] = ci;
      for (int i = 0; i < WIDTH; i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
    end

  end else if (ARCH == AU_ARCH_SKLANSKY || ARCH == AU_ARCH_KOGGE_STONE) begin : g_prefix

    logic [N-1:0] gg [LEVELS+1];
    logic [N-1:0] pp [LEVELS+1];

    // NOTE: every level is fully copied from the level below before any node
    // is combined, so each element has a default and no latch is inferred.
    always_comb begin
      int j;
      gg[0] = {g, ci};
      pp[0] = {p, 1'b0};
      for (int l = 0; l < LEVELS; l++) begin
        gg[l+1] = gg[l];
        pp[l+1] = pp[l];
        for (int i = 0; i < N; i++) begin
          if (ARCH == AU_ARCH_KOGGE_STONE) begin
            j = (i >= (1 << l)) ? i - (1 << l) : -1;
          end else begin
            // Sklansky: upper half of each 2^(l+1) block takes the prefix
            // ending just below its half boundary.
            j = (((i >> l) & 1) == 1) ? ((i >> l) << l) - 1 : -1;
          end
          if (j >= 0) begin
            gg[l+1][i] = gg[l][i] | (pp[l][i] & gg[l][j]);
            pp[l+1][i] = pp[l][i] & pp[l][j];
          end
        end
      end
      c = gg[LEVELS];
    end

  end else begin : g_bad_arch

    $error("au_carry_net: unsupported ARCH value %0d", ARCH);

  end

endmodule

// File: rtl/au_add_ovf.sv
// Registered two's-complement adder with carry-in and signed-overflow flag.
// One cycle of latency, a new operand set accepted every cycle.
module au_add_ovf
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = AU_ARCH_RCA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             v
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  assign g = a & b;
  assign p = a ^ b;

  au_carry_net #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_carry_net (
    .g  (g),
    .p  (p),
    .ci (ci),
    .c  (c)
  );

  assign sum = p ^ c[WIDTH-1:0];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      v <= 1'b0;
    end else begin
      s <= sum;
      v <= ovf;
    end
  end

endmodule

// File: tb/tb_au_add_ovf.sv
// Self-checking bench: nine adders (WIDTH 8/13/32 x ARCH 0/1/2) driven with
// directed and random operands and compared with an arithmetic model.
module tb_au_add_ovf;

  logic        clk = 1'b0;
  logic        rst;
  logic        ci;
  logic [7:0]  a8,  b8;
  logic [12:0] a13, b13;
  logic [31:0] a32, b32;

  logic [7:0]  s8  [3];
  logic [12:0] s13 [3];
  logic [31:0] s32 [3];
  logic        v8  [3];
  logic        v13 [3];
  logic        v32 [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    au_add_ovf #(.WIDTH(8),  .ARCH(k)) u_w8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .ci(ci), .s(s8[k]),  .v(v8[k]));
    au_add_ovf #(.WIDTH(13), .ARCH(k)) u_w13 (.clk(clk), .rst(rst), .a(a13), .b(b13), .ci(ci), .s(s13[k]), .v(v13[k]));
    au_add_ovf #(.WIDTH(32), .ARCH(k)) u_w32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .ci(ci), .s(s32[k]), .v(v32[k]));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum modulo 2^w, overflow from the true signed sum.
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic cv, output logic [63:0] se, output logic ve);
    longint unsigned mask;
    longint sa, sb, total, hi, lo;
    mask  = (longint'(1) << w) - 1;
    sa    = av[w-1] ? longint'(av & mask) - (longint'(1) << w) : longint'(av & mask);
    sb    = bv[w-1] ? longint'(bv & mask) - (longint'(1) << w) : longint'(bv & mask);
    total = sa + sb + longint'(cv);
    hi    = (longint'(1) << (w - 1)) - 1;
    lo    = -(longint'(1) << (w - 1));
    se    = (av + bv + 64'(cv)) & mask;
    ve    = (total > hi) || (total < lo);
  endfunction

  // Compare every instance with the model for operands (av, bv, cv).
  task automatic check_all(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic cv, input logic in_reset);
    logic [63:0] se8, se13, se32;
    logic        ve8, ve13, ve32;
    model(8,  64'(av), 64'(bv), cv, se8,  ve8);
    model(13, 64'(av), 64'(bv), cv, se13, ve13);
    model(32, 64'(av), 64'(bv), cv, se32, ve32);
    if (in_reset) begin
      se8 = '0; se13 = '0; se32 = '0;
      ve8 = 1'b0; ve13 = 1'b0; ve32 = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s w8_arch%0d_s",  tag, k), 64'(s8[k]),  se8);
      check($sformatf("%s w8_arch%0d_v",  tag, k), 64'(v8[k]),  64'(ve8));
      check($sformatf("%s w13_arch%0d_s", tag, k), 64'(s13[k]), se13);
      check($sformatf("%s w13_arch%0d_v", tag, k), 64'(v13[k]), 64'(ve13));
      check($sformatf("%s w32_arch%0d_s", tag, k), 64'(s32[k]), se32);
      check($sformatf("%s w32_arch%0d_v", tag, k), 64'(v32[k]), 64'(ve32));
    end
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    a8  = av[7:0];  b8  = bv[7:0];
    a13 = av[12:0]; b13 = bv[12:0];
    a32 = av;       b32 = bv;
    ci  = cv;
  endtask

  // Apply one operand set, clock it in, then check one step after the edge.
  task automatic step(input string tag, input logic [31:0] av, input logic [31:0] bv, input logic cv);
    drive(av, bv, cv);
    @(posedge clk);
    #1;
    check_all(tag, av, bv, cv, rst);
  endtask

  // Explicit 8-bit expectations for the named corner cases.
  task automatic step8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] s_exp, input logic v_exp);
    step(tag, 32'(av), 32'(bv), cv);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s fixed_arch%0d_s", tag, k), 64'(s8[k]), 64'(s_exp));
      check($sformatf("%s fixed_arch%0d_v", tag, k), 64'(v8[k]), 64'(v_exp));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h55, 32'h22, 1'b1);

    for (int e = 0; e < 3; e++) begin
      step8("reset_hold", 8'h55, 8'h22, 1'b1, 8'h00, 1'b0);
    end
    rst = 1'b0;
    step8("reset_release", 8'h55, 8'h22, 1'b1, 8'h78, 1'b0);

    step8("pos_ovf",       8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
    step8("pos_ovf_ci",    8'h7F, 8'h00, 1'b1, 8'h80, 1'b1);
    step8("neg_ovf",       8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    step8("unsigned_wrap", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b0);
    step8("all_ones",      8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0);
    step8("all_zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step8("zero_plus_m1",  8'h00, 8'hFF, 1'b1, 8'h00, 1'b0);

    // Mid-stream reset: the result captured on the previous edge is dropped.
    step("pre_reset", 32'h1234_5678, 32'h7654_3210, 1'b1);
    rst = 1'b1;
    step("mid_reset", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    rst = 1'b0;
    step("post_reset", 32'h8000_0000, 32'h8000_0000, 1'b1);

    // All-zero / all-one operand and carry combinations at every width.
    for (int m = 0; m < 8; m++) begin
      step("corner", m[0] ? 32'hFFFF_FFFF : 32'h0, m[1] ? 32'hFFFF_FFFF : 32'h0, m[2]);
    end

    for (int n = 0; n < 10000; n++) begin
      step("random", $urandom, $urandom, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
